mul_pipe_fu: RTL

Parametrised, pipelined integer multiply functional unit for the RV32M multiply group (MUL, MULH, MULHSU, MULHU). It replaces the single-cycle combinational multiplier with a STAGES-deep partial-product pipeline. It has a valid/ready handshake toward issue, backpressure from the complete stage, and a global flush on branch mispredict. It sits between the issue stage (MUL lanes) and the complete/CDB arbiter.

---
 rtl/mul_pipe_fu_pkg.sv | 39 +++
 rtl/mul_pipe_fu_stage.sv | 55 +++++
 rtl/mul_pipe_fu.sv | 110 +++++++++++
 3 files changed

// File: rtl/mul_pipe_fu_pkg.sv
// Shared definitions for the pipelined RV32M multiply unit: funct3 codes,
// the default-width stage record and operand-extension helpers.
package mul_pipe_fu_pkg;

    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_TAG_W = 7;
    localparam int DEF_ROB_W = 6;

    // Stage record at the default configuration; the top rebuilds the same
    // shape from its own parameters and hands it to the stages as a type.
    typedef struct packed {
        logic                  valid;
        logic [2:0]            funct3;
        logic [2*DEF_XLEN-1:0] mcand;
        logic [2*DEF_XLEN-1:0] mplier;
        logic [2*DEF_XLEN-1:0] acc;
        logic [DEF_TAG_W-1:0]  dest_prf;
        logic [DEF_ROB_W-1:0]  rob_idx;
    } mul_stage_t;

    // Any funct3 outside MUL/MULH/MULHSU behaves as MULHU.
    function automatic logic mcand_signed(input logic [2:0] funct3);
        return (funct3 == M_MUL) || (funct3 == M_MULH) || (funct3 == M_MULHSU);
    endfunction

    function automatic logic mplier_signed(input logic [2:0] funct3);
        return (funct3 == M_MUL) || (funct3 == M_MULH);
    endfunction

    function automatic logic result_is_low(input logic [2:0] funct3);
        return funct3 == M_MUL;
    endfunction

endpackage

// File: rtl/mul_pipe_fu_stage.sv
// One partial-product stage: folds one multiplier chunk into the running
// accumulator and registers the whole op record.
module mul_pp_stage
    import mul_pipe_fu_pkg::*;
#(
    parameter int  XLEN      = DEF_XLEN,
    parameter int  STAGES    = 4,
    parameter int  STAGE_IDX = 0,
    parameter type stage_t   = mul_stage_t
) (
    input  logic   clock,
    input  logic   reset_n,
    input  logic   flush_i,
    input  logic   advance_i,
    input  stage_t stage_i,
    output stage_t stage_o
);

    localparam int W2    = 2 * XLEN;
    localparam int CHUNK = W2 / STAGES;
    localparam int SHIFT = STAGE_IDX * CHUNK;

    logic [CHUNK-1:0] mplier_chunk;
    logic [W2-1:0]    product;
    logic [W2-1:0]    partial;
    stage_t           stage_d;
    stage_t           stage_q;

    // The chunk is taken as unsigned: with the multiplier already extended
    // to 2*XLEN, summing unsigned chunks gives the exact product mod 2^(2*XLEN).
    always_comb begin
        mplier_chunk = stage_i.mplier[SHIFT +: CHUNK];
        product      = stage_i.mcand * W2'(mplier_chunk);
        partial      = product << SHIFT;

        stage_d = stage_q;
        if (flush_i) begin
            stage_d.valid = 1'b0;
        end else if (advance_i) begin
            stage_d     = stage_i;
            stage_d.acc = stage_i.acc + partial;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/mul_pipe_fu.sv
// Pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU) with issue handshake,
// complete-stage backpressure and mispredict flush.
module mul_pipe_fu
    import mul_pipe_fu_pkg::*;
#(
    parameter int  XLEN      = 32,
    parameter int  STAGES    = 4,
    parameter int  PHYS_REGS = 128,
    parameter int  ROB_DEPTH = 64,
    localparam int TAG_W     = $clog2(PHYS_REGS),
    localparam int ROB_W     = $clog2(ROB_DEPTH),
    localparam int BUSY_W    = $clog2(STAGES + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_funct3_i,
    input  logic [XLEN-1:0]   req_src1_i,
    input  logic [XLEN-1:0]   req_src2_i,
    input  logic [TAG_W-1:0]  req_dest_prf_i,
    input  logic [ROB_W-1:0]  req_rob_idx_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [XLEN-1:0]   resp_value_o,
    output logic [TAG_W-1:0]  resp_dest_prf_o,
    output logic [ROB_W-1:0]  resp_rob_idx_o,
    output logic [BUSY_W-1:0] busy_o
);

    typedef struct packed {
        logic              valid;
        logic [2:0]        funct3;
        logic [2*XLEN-1:0] mcand;
        logic [2*XLEN-1:0] mplier;
        logic [2*XLEN-1:0] acc;
        logic [TAG_W-1:0]  dest_prf;
        logic [ROB_W-1:0]  rob_idx;
    } stage_t;

    stage_t            req_stage;
    stage_t            stage_in  [STAGES];
    stage_t            stage_out [STAGES];
    stage_t            tail;
    logic              advance;
    logic              accept;
    logic [BUSY_W-1:0] busy_cnt;
    logic              unused_tail;

    assign tail    = stage_out[STAGES-1];
    // Whole-pipe stall: bubbles are not squeezed out behind a blocked result.
    assign advance = !tail.valid || resp_ready_i;
    assign accept  = req_valid_i && advance && !flush_i;

    always_comb begin
        req_stage          = '0;
        req_stage.valid    = accept;
        req_stage.funct3   = req_funct3_i;
        req_stage.mcand    = mcand_signed(req_funct3_i)
                           ? {{XLEN{req_src1_i[XLEN-1]}}, req_src1_i}
                           : {{XLEN{1'b0}}, req_src1_i};
        req_stage.mplier   = mplier_signed(req_funct3_i)
                           ? {{XLEN{req_src2_i[XLEN-1]}}, req_src2_i}
                           : {{XLEN{1'b0}}, req_src2_i};
        req_stage.dest_prf = req_dest_prf_i;
        req_stage.rob_idx  = req_rob_idx_i;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign stage_in[k] = req_stage;
        end else begin : g_link
            assign stage_in[k] = stage_out[k-1];
        end

        mul_pp_stage #(
            .XLEN      (XLEN),
            .STAGES    (STAGES),
            .STAGE_IDX (k),
            .stage_t   (stage_t)
        ) u_stage (
            .clock     (clock),
            .reset_n   (reset_n),
            .flush_i   (flush_i),
            .advance_i (advance),
            .stage_i   (stage_in[k]),
            .stage_o   (stage_out[k])
        );
    end

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < STAGES; i++) begin
            busy_cnt = busy_cnt + BUSY_W'(stage_out[i].valid);
        end
    end

    assign req_ready_o     = advance;
    assign resp_valid_o    = tail.valid;
    assign resp_value_o    = result_is_low(tail.funct3) ? tail.acc[XLEN-1:0]
                                                        : tail.acc[2*XLEN-1:XLEN];
    assign resp_dest_prf_o = tail.dest_prf;
    assign resp_rob_idx_o  = tail.rob_idx;
    assign busy_o          = busy_cnt;

    // Operands are fully consumed by the last stage; only acc leaves the unit.
    assign unused_tail = ^{tail.mcand, tail.mplier};

endmodule
